// File: rtl/ads8588h_ser_ctrl_if.sv
// Pin and sample bus bundle for the ADS8588H serial-mode controller.
// The master side is the controller. The slave side is the ADC pins
// together with the downstream sample consumer.
interface ads8588h_ser_ctrl_if;
  logic        start;
  logic        adc_convst;
  logic        adc_busy;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_douta;
  logic        adc_doutb;
  logic        adc_reset;
  logic        adc_par_ser;
  logic        ctrl_busy;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_a;
  logic [15:0] sample_b;
  logic        timeout_err;

  modport master (
    input  start, adc_busy, adc_douta, adc_doutb,
    output adc_convst, adc_cs_n, adc_sclk, adc_reset, adc_par_ser,
    output ctrl_busy, sample_valid, sample_ch, sample_a, sample_b, timeout_err
  );

  modport slave (
    output start, adc_busy, adc_douta, adc_doutb,
    input  adc_convst, adc_cs_n, adc_sclk, adc_reset, adc_par_ser,
    input  ctrl_busy, sample_valid, sample_ch, sample_a, sample_b, timeout_err
  );
endinterface

// File: rtl/ads8588h_ser_ctrl.sv
// ADS8588H serial-mode host controller.
// It resets the ADC, issues CONVST, and tracks BUSY with timeouts. It then
// frames CS, generates SCLK, and deserialises DOUTA (ch1-4) and DOUTB (ch5-8)
// into 16-bit word pairs, which it emits as one strobe per channel pair.
// All outputs are registered.
module ads8588h_ser_ctrl #(
  parameter int CLK_DIV  = 1,
  parameter int T_CNV_HI = 20,
  parameter int T_RST    = 17,
  parameter int BUSY_TO  = 32,
  parameter int NCH      = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  ads8588h_ser_ctrl_if.master   bus
);

  localparam int CW    = 16;
  localparam int NBITS = 16 * NCH;
  localparam int BW    = $clog2(NBITS) + 1;
  localparam int DW    = $clog2(CLK_DIV) + 1;

  localparam logic [CW-1:0] T_RST_C   = CW'(T_RST);
  localparam logic [CW-1:0] T_CNV_C   = CW'(T_CNV_HI);
  localparam logic [CW-1:0] BUSY_TO_C = CW'(BUSY_TO);
  localparam logic [BW-1:0] NBITS_C   = BW'(NBITS);
  localparam logic [DW-1:0] DIV_END_C = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_ADC_RST      = 3'd0,
    ST_IDLE         = 3'd1,
    ST_CNV_HI       = 3'd2,
    ST_WAIT_BUSY_HI = 3'd3,
    ST_WAIT_BUSY_LO = 3'd4,
    ST_CS_SETUP     = 3'd5,
    ST_SHIFT        = 3'd6,
    ST_CS_END       = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;          // ADC_RST / CONVST phase length
  logic [CW-1:0] to_q, to_d;            // cycles since CONVST rise
  logic [CW-1:0] bh_q, bh_d;            // cycles BUSY observed high
  logic          busy_seen_q, busy_seen_d;
  logic [DW-1:0] div_q, div_d;          // position within an SCLK half-period
  logic [BW-1:0] bit_q, bit_d;          // bits shifted in this frame
  logic [15:0]   sh_a_q, sh_a_d;
  logic [15:0]   sh_b_q, sh_b_d;

  logic          adc_convst_q, adc_convst_d;
  logic          adc_cs_n_q, adc_cs_n_d;
  logic          adc_sclk_q, adc_sclk_d;
  logic          adc_reset_q, adc_reset_d;
  logic          ctrl_busy_q, ctrl_busy_d;
  logic          sample_valid_q, sample_valid_d;
  logic [1:0]    sample_ch_q, sample_ch_d;
  logic [15:0]   sample_a_q, sample_a_d;
  logic [15:0]   sample_b_q, sample_b_d;
  logic          timeout_err_q, timeout_err_d;

  // Next-state and next-output computation for the conversion/readout sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_d           = to_q;
    bh_d           = bh_q;
    busy_seen_d    = busy_seen_q;
    div_d          = div_q;
    bit_d          = bit_q;
    sh_a_d         = sh_a_q;
    sh_b_d         = sh_b_q;
    adc_convst_d   = adc_convst_q;
    adc_cs_n_d     = adc_cs_n_q;
    adc_sclk_d     = adc_sclk_q;
    adc_reset_d    = adc_reset_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_a_d     = sample_a_q;
    sample_b_d     = sample_b_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      ST_ADC_RST: begin
        if (cnt_q == T_RST_C) begin
          adc_reset_d = 1'b0;
          cnt_d       = {CW{1'b0}};
          state_d     = ST_IDLE;
        end else begin
          adc_reset_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
        end
      end

      ST_IDLE: begin
        if (bus.start) begin
          adc_convst_d = 1'b1;
          cnt_d        = CW'(1);
          to_d         = CW'(1);
          bh_d         = {CW{1'b0}};
          busy_seen_d  = 1'b0;
          state_d      = ST_CNV_HI;
        end else begin
          adc_convst_d = 1'b0;
        end
      end

      // BUSY rises tens of ns after CONVST and a short conversion can even
      // finish while CONVST is still high, so BUSY is already watched here.
      ST_CNV_HI: begin
        to_d = to_q + CW'(1);
        if (bus.adc_busy) begin
          busy_seen_d = 1'b1;
          bh_d        = bh_q + CW'(1);
        end else begin
          bh_d        = bh_q;
        end
        if (cnt_q == T_CNV_C) begin
          adc_convst_d = 1'b0;
          state_d      = ST_WAIT_BUSY_HI;
        end else begin
          cnt_d        = cnt_q + CW'(1);
        end
      end

      ST_WAIT_BUSY_HI: begin
        to_d = to_q + CW'(1);
        if (busy_seen_q || bus.adc_busy) begin
          busy_seen_d = 1'b1;
          state_d     = ST_WAIT_BUSY_LO;
        end else if (to_q >= BUSY_TO_C) begin
          timeout_err_d = 1'b1;
          cnt_d         = {CW{1'b0}};
          state_d       = ST_ADC_RST;
        end else begin
          state_d       = ST_WAIT_BUSY_HI;
        end
      end

      ST_WAIT_BUSY_LO: begin
        if (!bus.adc_busy) begin
          adc_cs_n_d = 1'b0;
          state_d    = ST_CS_SETUP;
        end else begin
          bh_d = bh_q + CW'(1);
          if (bh_d >= BUSY_TO_C) begin
            timeout_err_d = 1'b1;
            cnt_d         = {CW{1'b0}};
            state_d       = ST_ADC_RST;
          end else begin
            state_d       = ST_WAIT_BUSY_LO;
          end
        end
      end

      // CS has been low for one cycle; the first SCLK low phase starts now.
      ST_CS_SETUP: begin
        adc_sclk_d = 1'b0;
        div_d      = {DW{1'b0}};
        bit_d      = {BW{1'b0}};
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_q == DIV_END_C) begin
          div_d = {DW{1'b0}};
          if (!adc_sclk_q) begin
            // SCLK low->high: take the bit the ADC has been presenting.
            adc_sclk_d = 1'b1;
            sh_a_d     = {sh_a_q[14:0], bus.adc_douta};
            sh_b_d     = {sh_b_q[14:0], bus.adc_doutb};
            bit_d      = bit_q + BW'(1);
            if (bit_q[3:0] == 4'hF) begin
              sample_a_d     = sh_a_d;
              sample_b_d     = sh_b_d;
              sample_ch_d    = 2'(bit_q >> 3'd4);
              sample_valid_d = 1'b1;
            end else begin
              sample_valid_d = 1'b0;
            end
          end else if (bit_q == NBITS_C) begin
            adc_cs_n_d = 1'b1;
            state_d    = ST_CS_END;
          end else begin
            adc_sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      ST_CS_END: begin
        adc_cs_n_d = 1'b1;
        adc_sclk_d = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        adc_convst_d = 1'b0;
        adc_cs_n_d   = 1'b1;
        adc_sclk_d   = 1'b1;
        cnt_d        = {CW{1'b0}};
        state_d      = ST_ADC_RST;
      end
    endcase

    ctrl_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset into ADC_RST.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= ST_ADC_RST;
      cnt_q          <= {CW{1'b0}};
      to_q           <= {CW{1'b0}};
      bh_q           <= {CW{1'b0}};
      busy_seen_q    <= 1'b0;
      div_q          <= {DW{1'b0}};
      bit_q          <= {BW{1'b0}};
      sh_a_q         <= 16'h0000;
      sh_b_q         <= 16'h0000;
      adc_convst_q   <= 1'b0;
      adc_cs_n_q     <= 1'b1;
      adc_sclk_q     <= 1'b1;
      adc_reset_q    <= 1'b0;
      ctrl_busy_q    <= 1'b1;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= 2'd0;
      sample_a_q     <= 16'h0000;
      sample_b_q     <= 16'h0000;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      bh_q           <= bh_d;
      busy_seen_q    <= busy_seen_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      sh_a_q         <= sh_a_d;
      sh_b_q         <= sh_b_d;
      adc_convst_q   <= adc_convst_d;
      adc_cs_n_q     <= adc_cs_n_d;
      adc_sclk_q     <= adc_sclk_d;
      adc_reset_q    <= adc_reset_d;
      ctrl_busy_q    <= ctrl_busy_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_a_q     <= sample_a_d;
      sample_b_q     <= sample_b_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.adc_convst   = adc_convst_q;
  assign bus.adc_cs_n     = adc_cs_n_q;
  assign bus.adc_sclk     = adc_sclk_q;
  assign bus.adc_reset    = adc_reset_q;
  assign bus.adc_par_ser  = 1'b1;
  assign bus.ctrl_busy    = ctrl_busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_a     = sample_a_q;
  assign bus.sample_b     = sample_b_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ads8588h_ser_ctrl.sv
// Scoreboard bench for ads8588h_ser_ctrl: one instance with CLK_DIV=1 and one
// with CLK_DIV=3. Each instance has a behavioural ADC model (BUSY plus serial
// data), and a monitor per instance pops expected sample pairs from a queue.
module tb_ads8588h_ser_ctrl;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 sys_clk = ~sys_clk;

  ads8588h_ser_ctrl_if ifa ();
  ads8588h_ser_ctrl_if ifb ();

  ads8588h_ser_ctrl #(.CLK_DIV(1)) dut_a (.sys_clk(sys_clk), .reset(reset), .bus(ifa.master));
  ads8588h_ser_ctrl #(.CLK_DIV(3)) dut_b (.sys_clk(sys_clk), .reset(reset), .bus(ifb.master));

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   busy_mode = 0;   // 0: BUSY pulses normally, 1: BUSY never rises

  logic [63:0] sa_a = 64'd0, sb_a = 64'd0, sa_b = 64'd0, sb_b = 64'd0;
  int ra_a = 0, oi_a = 0, falls_a = 0, strobes_a = 0;
  int ra_b = 0, oi_b = 0, falls_b = 0, strobes_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Load the ADC data streams for an instance and queue the expected words.
  task automatic load_frame(input int inst, input logic [63:0] wa, input logic [63:0] wb,
                            input int nwords);
    exp_t e;
    if (inst == 0) begin sa_a = wa; sb_a = wb; end
    else begin sa_b = wa; sb_b = wb; end
    for (int k = 0; k < nwords; k++) begin
      e.ch = 2'(k);
      e.a  = wa[63-16*k -: 16];
      e.b  = wb[63-16*k -: 16];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int inst);
    @(negedge sys_clk);
    if (inst == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge sys_clk);
    if (inst == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int budget, input string name);
    int n;
    n = 0;
    while (((inst == 0) ? ifa.ctrl_busy : ifb.ctrl_busy) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(name, (inst == 0) ? ifa.ctrl_busy : ifb.ctrl_busy, 32'd0);
  endtask

  // ADC BUSY model: rises one cycle after CONVST rises and stays high 13 cycles.
  initial begin
    ifa.adc_busy = 1'b0;
    forever begin
      @(posedge ifa.adc_convst);
      if (busy_mode == 0) begin
        @(negedge sys_clk); ifa.adc_busy = 1'b1;
        repeat (13) @(negedge sys_clk);
        ifa.adc_busy = 1'b0;
      end
    end
  end

  initial begin
    ifb.adc_busy = 1'b0;
    forever begin
      @(posedge ifb.adc_convst);
      if (busy_mode == 0) begin
        @(negedge sys_clk); ifb.adc_busy = 1'b1;
        repeat (13) @(negedge sys_clk);
        ifb.adc_busy = 1'b0;
      end
    end
  end

  // Serial data model: MSB at CS fall; the following SCLK fall presents the bit after each sampled one.
  always @(posedge ifa.adc_cs_n or posedge ifa.adc_sclk)
    if (ifa.adc_cs_n) ra_a = 0; else ra_a = ra_a + 1;
  always @(negedge ifa.adc_sclk or negedge ifa.adc_cs_n)
    if (!ifa.adc_cs_n) begin
      oi_a = (ra_a > 63) ? 63 : ra_a;
      if (!ifa.adc_sclk) falls_a = falls_a + 1;
    end
  assign ifa.adc_douta = sa_a[6'(63 - oi_a)];
  assign ifa.adc_doutb = sb_a[6'(63 - oi_a)];

  always @(posedge ifb.adc_cs_n or posedge ifb.adc_sclk)
    if (ifb.adc_cs_n) ra_b = 0; else ra_b = ra_b + 1;
  always @(negedge ifb.adc_sclk or negedge ifb.adc_cs_n)
    if (!ifb.adc_cs_n) begin
      oi_b = (ra_b > 63) ? 63 : ra_b;
      if (!ifb.adc_sclk) falls_b = falls_b + 1;
    end
  assign ifb.adc_douta = sa_b[6'(63 - oi_b)];
  assign ifb.adc_doutb = sb_b[6'(63 - oi_b)];

  // Monitor for instance A: compare every strobe against the scoreboard queue.
  always @(negedge sys_clk) begin
    exp_t e;
    if (ifa.sample_valid === 1'b1) begin
      strobes_a = strobes_a + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL strobe_a_unexpected: got ch=%0d a=%h b=%h, required no strobe",
                 ifa.sample_ch, ifa.sample_a, ifa.sample_b);
      end else begin
        e = exp_q.pop_front();
        if ({ifa.sample_ch, ifa.sample_a, ifa.sample_b} !== e) begin
          failures = failures + 1;
          $display("FAIL sample_a_pair: got ch=%0d a=%h b=%h, required ch=%0d a=%h b=%h",
                   ifa.sample_ch, ifa.sample_a, ifa.sample_b, e.ch, e.a, e.b);
        end
      end
    end
  end

  // Monitor for instance B: compare every strobe against the scoreboard queue.
  always @(negedge sys_clk) begin
    exp_t e;
    if (ifb.sample_valid === 1'b1) begin
      strobes_b = strobes_b + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL strobe_b_unexpected: got ch=%0d a=%h b=%h, required no strobe",
                 ifb.sample_ch, ifb.sample_a, ifb.sample_b);
      end else begin
        e = exp_q.pop_front();
        if ({ifb.sample_ch, ifb.sample_a, ifb.sample_b} !== e) begin
          failures = failures + 1;
          $display("FAIL sample_b_pair: got ch=%0d a=%h b=%h, required ch=%0d a=%h b=%h",
                   ifb.sample_ch, ifb.sample_a, ifb.sample_b, e.ch, e.a, e.b);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nr, s0, f0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_cs_n", ifa.adc_cs_n, 32'd1);
    chk("rst_sclk", ifa.adc_sclk, 32'd1);
    chk("rst_convst", ifa.adc_convst, 32'd0);
    chk("rst_adc_reset", ifa.adc_reset, 32'd0);
    chk("rst_valid", ifa.sample_valid, 32'd0);
    chk("rst_ch", ifa.sample_ch, 32'd0);
    chk("rst_sample_a", ifa.sample_a, 32'd0);
    chk("rst_sample_b", ifa.sample_b, 32'd0);
    chk("rst_timeout", ifa.timeout_err, 32'd0);
    chk("rst_ctrl_busy", ifa.ctrl_busy, 32'd1);
    chk("rst_par_ser", ifa.adc_par_ser, 32'd1);
    reset = 1'b0;

    // ADC reset pulse after release
    n = 0; nr = 0; s0 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (!ifa.ctrl_busy) break;
      n++;
      if (ifa.adc_reset) nr++;
      if (ifa.adc_cs_n !== 1'b1 || ifa.adc_sclk !== 1'b1) s0++;
    end
    chk("adc_reset_cycles", nr, 32'd17);
    chk("rst_busy_cycles", n, 32'd17);
    chk("rst_pins_idle", s0, 32'd0);
    chk("rst_done_idle", ifa.ctrl_busy, 32'd0);
    chk("rst_done_adc_reset", ifa.adc_reset, 32'd0);
    wait_idle(1, 10, "rst_b_idle");

    // Normal frame
    load_frame(0, {16'h1234, 16'hABCD, 16'h0000, 16'hFFFF},
                  {16'h8001, 16'h7FFE, 16'h5555, 16'hAAAA}, 4);
    s0 = strobes_a; f0 = falls_a;
    pulse_start(0);
    n = 0;
    while (ifa.adc_convst && n < 100) begin n++; @(negedge sys_clk); end
    chk("convst_high_cycles", n, 32'd20);
    wait_idle(0, 400, "frame1_idle");
    chk("frame1_strobes", strobes_a - s0, 32'd4);
    chk("frame1_sclk_falls", falls_a - f0, 32'd64);
    chk("frame1_queue_empty", exp_q.size(), 32'd0);
    chk("frame1_hold_a", ifa.sample_a, 32'h0000FFFF);
    chk("frame1_hold_b", ifa.sample_b, 32'h0000AAAA);
    chk("frame1_hold_ch", ifa.sample_ch, 32'd3);
    chk("frame1_no_timeout", ifa.timeout_err, 32'd0);
    chk("frame1_cs_n", ifa.adc_cs_n, 32'd1);

    // start during SHIFT is ignored
    load_frame(0, {16'h0F0F, 16'h1111, 16'h2222, 16'h3333},
                  {16'hF0F0, 16'h4444, 16'h6666, 16'h7777}, 4);
    s0 = strobes_a;
    pulse_start(0);
    n = 0;
    while (ifa.adc_cs_n && n < 100) begin n++; @(negedge sys_clk); end
    chk("frame2_cs_low", ifa.adc_cs_n, 32'd0);
    repeat (10) @(negedge sys_clk);
    pulse_start(0);
    wait_idle(0, 400, "frame2_idle");
    chk("frame2_strobes", strobes_a - s0, 32'd4);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      if (ifa.adc_convst || ifa.ctrl_busy) n++;
    end
    chk("frame2_no_queued_start", n, 32'd0);
    load_frame(0, {16'h0102, 16'h0304, 16'h0506, 16'h0708},
                  {16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10}, 4);
    s0 = strobes_a;
    pulse_start(0);
    wait_idle(0, 400, "frame3_idle");
    chk("frame3_strobes", strobes_a - s0, 32'd4);
    chk("frame3_queue_empty", exp_q.size(), 32'd0);

    // BUSY never rises: timeout
    busy_mode = 1;
    s0 = strobes_a;
    pulse_start(0);
    n = 0;
    while (!ifa.timeout_err && n < 100) begin @(negedge sys_clk); n++; end
    chk("timeout_cycles", n, 32'd32);
    nr = 0; n = 0;
    while (ifa.ctrl_busy && n < 100) begin
      @(negedge sys_clk);
      n++;
      if (ifa.adc_reset) nr++;
    end
    chk("timeout_adc_reset_cycles", nr, 32'd17);
    chk("timeout_sticky", ifa.timeout_err, 32'd1);
    chk("timeout_no_strobes", strobes_a - s0, 32'd0);
    chk("timeout_convst_low", ifa.adc_convst, 32'd0);
    busy_mode = 0;
    @(negedge sys_clk); reset = 1'b1;
    @(negedge sys_clk); reset = 1'b0;
    chk("timeout_cleared", ifa.timeout_err, 32'd0);
    wait_idle(0, 40, "post_timeout_idle");
    wait_idle(1, 40, "post_timeout_b_idle");

    // reset after 20 SCLK periods: only word 0 is delivered
    load_frame(0, {16'hDEAD, 16'h1357, 16'h2468, 16'h9999},
                  {16'hBEEF, 16'h8642, 16'h7531, 16'h6666}, 1);
    s0 = strobes_a;
    pulse_start(0);
    n = 0;
    while (ra_a < 20 && n < 400) begin @(negedge sys_clk); n++; end
    chk("midrst_reached_20", (ra_a >= 20) ? 32'd1 : 32'd0, 32'd1);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("midrst_cs_n", ifa.adc_cs_n, 32'd1);
    chk("midrst_sclk", ifa.adc_sclk, 32'd1);
    chk("midrst_convst", ifa.adc_convst, 32'd0);
    chk("midrst_sample_a", ifa.sample_a, 32'd0);
    chk("midrst_sample_b", ifa.sample_b, 32'd0);
    chk("midrst_valid", ifa.sample_valid, 32'd0);
    @(negedge sys_clk); reset = 1'b0;
    wait_idle(0, 60, "midrst_idle");
    repeat (20) @(negedge sys_clk);
    chk("midrst_strobes", strobes_a - s0, 32'd1);
    chk("midrst_queue_empty", exp_q.size(), 32'd0);
    wait_idle(1, 40, "midrst_b_idle");

    // CLK_DIV=3 instance
    load_frame(1, {16'hC3A5, 16'h0001, 16'h8000, 16'h1357},
                  {16'hC3A5, 16'hFFFE, 16'h7FFF, 16'h2468}, 4);
    s0 = strobes_b; f0 = falls_b;
    pulse_start(1);
    n = 0;
    while (ifb.adc_cs_n && n < 100) begin n++; @(negedge sys_clk); end
    n = 0;
    while (ifb.adc_sclk && n < 20) begin n++; @(negedge sys_clk); end
    n = 0;
    while (!ifb.adc_sclk && n < 20) begin n++; @(negedge sys_clk); end
    chk("div3_sclk_low", n, 32'd3);
    n = 0;
    while (ifb.adc_sclk && n < 20) begin n++; @(negedge sys_clk); end
    chk("div3_sclk_high", n, 32'd3);
    wait_idle(1, 800, "div3_idle");
    chk("div3_strobes", strobes_b - s0, 32'd4);
    chk("div3_sclk_falls", falls_b - f0, 32'd64);
    chk("div3_queue_empty", exp_q.size(), 32'd0);
    chk("div3_hold_a", ifb.sample_a, 32'h00001357);

    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
